// File: rtl/msdap_pkg.sv
// Shared constants, state encoding and payload types for the MSDAP front-end sequencer.
package msdap_pkg;

    localparam int unsigned RJ_DEPTH    = 16;
    localparam int unsigned COEFF_DEPTH = 512;
    localparam int unsigned DATA_DEPTH  = 256;
    localparam int unsigned ZERO_LIMIT  = 800;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned RJ_AW    = $clog2(RJ_DEPTH);
    localparam int unsigned COEFF_AW = $clog2(COEFF_DEPTH);
    localparam int unsigned DATA_AW  = $clog2(DATA_DEPTH);
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned CNT_W    = COEFF_AW;
    localparam int unsigned ZERO_W   = $clog2(ZERO_LIMIT + 1);

    typedef enum logic [STATE_W-1:0] {
        ST_INIT       = 4'd0,
        ST_WAIT_RJ    = 4'd1,
        ST_READ_RJ    = 4'd2,
        ST_WAIT_COEFF = 4'd3,
        ST_READ_COEFF = 4'd4,
        ST_WAIT_INPUT = 4'd5,
        ST_WORKING    = 4'd6,
        ST_SLEEP      = 4'd7,
        ST_CLEARING   = 4'd8
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] left;
        logic [WORD_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/msdap_ctrl_if.sv
// Deserializer / datapath facing signal bundle of the MSDAP sequencer.
interface msdap_ctrl_if;
    import msdap_pkg::*;

    logic                in_flag;
    logic [WORD_W-1:0]   dataL;
    logic [WORD_W-1:0]   dataR;
    logic                Flush;
    logic                compute_busy;

    logic                InReady;
    logic                rj_we;
    logic [RJ_AW-1:0]    rj_addr;
    logic                coeff_we;
    logic [COEFF_AW-1:0] coeff_addr;
    logic                data_we;
    logic [DATA_AW-1:0]  data_addr;
    logic                data_zero;
    logic                start_compute;
    logic [DATA_AW-1:0]  newest_ptr;
    logic                Sleep_flag;
    logic [STATE_W-1:0]  state;
    logic                err_overrun;

    modport master (
        output in_flag, dataL, dataR, Flush, compute_busy,
        input  InReady, rj_we, rj_addr, coeff_we, coeff_addr, data_we, data_addr,
               data_zero, start_compute, newest_ptr, Sleep_flag, state, err_overrun
    );

    modport slave (
        input  in_flag, dataL, dataR, Flush, compute_busy,
        output InReady, rj_we, rj_addr, coeff_we, coeff_addr, data_we, data_addr,
               data_zero, start_compute, newest_ptr, Sleep_flag, state, err_overrun
    );

endinterface

// File: rtl/msdap_zero_detect.sv
// Saturating count of consecutive all-zero stereo samples; flags the sample that reaches the limit.
module msdap_zero_detect
    import msdap_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    valid,
    input  stereo_t sample,
    input  logic    restart,
    output logic    limit_reached_c
);

    logic [ZERO_W-1:0] zero_cnt;
    logic              is_zero_c;

    assign is_zero_c       = (sample.left == '0) && (sample.right == '0);
    assign limit_reached_c = valid && is_zero_c && (zero_cnt == ZERO_W'(ZERO_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            zero_cnt <= '0;
        end else if (valid) begin
            if (!is_zero_c) begin
                zero_cnt <= '0;
            end else if (zero_cnt != ZERO_W'(ZERO_LIMIT)) begin
                zero_cnt <= zero_cnt + ZERO_W'(1);
            end
        end
    end

endmodule

// File: rtl/msdap_ctrl.sv
// MSDAP main sequencer: loads Rj and coefficient memories, streams samples into the
// circular data memory, kicks the filter engine, and manages sleep and flush.
module msdap_ctrl
    import msdap_pkg::*;
(
    input  logic         Sclk,
    input  logic         Clear,
    msdap_ctrl_if.slave  bus
);

    state_e               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [DATA_AW-1:0]   ptr_q, ptr_n;
    logic                 clr_done_q, clr_done_n;
    logic                 start_pend_q;

    logic                 rj_we_d, coeff_we_d, data_we_d, data_zero_d, start_d, ready_d;
    logic [CNT_W-1:0]     addr_d;
    logic                 sample_c, restart_c, limit_c, word_zero_c;
    stereo_t              word_c;

    assign word_c      = '{left: bus.dataL, right: bus.dataR};
    assign word_zero_c = (bus.dataL == '0) && (bus.dataR == '0);

    msdap_zero_detect u_zero_detect (
        .clk             (Sclk),
        .rst             (Clear),
        .valid           (sample_c),
        .sample          (word_c),
        .restart         (restart_c),
        .limit_reached_c (limit_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        ptr_n       = ptr_q;
        clr_done_n  = clr_done_q;
        rj_we_d     = 1'b0;
        coeff_we_d  = 1'b0;
        data_we_d   = 1'b0;
        data_zero_d = 1'b0;
        start_d     = 1'b0;
        addr_d      = cnt_q;
        sample_c    = 1'b0;
        restart_c   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                data_we_d   = 1'b1;
                data_zero_d = 1'b1;
                if (cnt_q == CNT_W'(DATA_DEPTH - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_RJ;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RJ, ST_READ_RJ: begin
                if (bus.in_flag) begin
                    rj_we_d = 1'b1;
                    if (cnt_q == CNT_W'(RJ_DEPTH - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_WAIT_COEFF;
                    end else begin
                        cnt_n   = cnt_q + CNT_W'(1);
                        state_n = ST_READ_RJ;
                    end
                end
            end
            ST_WAIT_COEFF, ST_READ_COEFF: begin
                if (bus.in_flag) begin
                    coeff_we_d = 1'b1;
                    if (cnt_q == CNT_W'(COEFF_DEPTH - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_WAIT_INPUT;
                    end else begin
                        cnt_n   = cnt_q + CNT_W'(1);
                        state_n = ST_READ_COEFF;
                    end
                end
            end
            ST_WAIT_INPUT, ST_WORKING, ST_SLEEP: begin
                // Flush beats a same-cycle word, which is dropped
                if (bus.Flush) begin
                    state_n    = ST_CLEARING;
                    cnt_n      = '0;
                    clr_done_n = 1'b0;
                end else if (bus.in_flag) begin
                    sample_c = 1'b1;
                    if (!(state_q == ST_SLEEP && word_zero_c)) begin
                        data_we_d = 1'b1;
                        addr_d    = CNT_W'(ptr_q);
                        ptr_n     = ptr_q + DATA_AW'(1);
                        start_d   = 1'b1;
                        state_n   = (state_q == ST_WORKING && limit_c) ? ST_SLEEP : ST_WORKING;
                    end
                end
            end
            ST_CLEARING: begin
                if (!clr_done_q) begin
                    data_we_d   = 1'b1;
                    data_zero_d = 1'b1;
                    if (cnt_q == CNT_W'(DATA_DEPTH - 1)) begin
                        cnt_n      = '0;
                        ptr_n      = '0;
                        restart_c  = 1'b1;
                        clr_done_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end else if (!bus.Flush) begin
                    state_n = ST_WAIT_INPUT;
                end
            end
            default: begin
                state_n = ST_INIT;
                cnt_n   = '0;
            end
        endcase

        ready_d = (state_n != ST_INIT) && (state_n != ST_CLEARING);
    end

    // State, counters and pointer
    always_ff @(posedge Sclk) begin
        if (Clear) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            ptr_q        <= '0;
            clr_done_q   <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            ptr_q        <= ptr_n;
            clr_done_q   <= clr_done_n;
            start_pend_q <= start_d;
        end
    end

    // Registered outputs; start_compute trails its data write by one cycle
    always_ff @(posedge Sclk) begin
        if (Clear) begin
            bus.InReady       <= 1'b0;
            bus.rj_we         <= 1'b0;
            bus.rj_addr       <= '0;
            bus.coeff_we      <= 1'b0;
            bus.coeff_addr    <= '0;
            bus.data_we       <= 1'b0;
            bus.data_addr     <= '0;
            bus.data_zero     <= 1'b0;
            bus.start_compute <= 1'b0;
            bus.newest_ptr    <= '0;
            bus.Sleep_flag    <= 1'b0;
            bus.state         <= ST_INIT;
            bus.err_overrun   <= 1'b0;
        end else begin
            bus.InReady    <= ready_d;
            bus.rj_we      <= rj_we_d;
            bus.coeff_we   <= coeff_we_d;
            bus.data_we    <= data_we_d;
            bus.data_zero  <= data_zero_d;
            bus.Sleep_flag <= (state_n == ST_SLEEP);
            bus.state      <= state_n;
            if (rj_we_d)    bus.rj_addr    <= RJ_AW'(addr_d);
            if (coeff_we_d) bus.coeff_addr <= COEFF_AW'(addr_d);
            if (data_we_d)  bus.data_addr  <= DATA_AW'(addr_d);
            bus.start_compute <= start_pend_q;
            if (start_pend_q) bus.newest_ptr <= bus.data_addr;
            bus.err_overrun <= bus.err_overrun | (bus.start_compute & bus.compute_busy);
        end
    end

endmodule

// File: tb/tb_msdap_ctrl.sv
// Directed self-checking bench for msdap_ctrl: load, stream, sleep/wake, flush, overrun.
module tb_msdap_ctrl;

    logic Sclk = 1'b0;
    logic Clear;

    msdap_ctrl_if bus ();

    msdap_ctrl dut (
        .Sclk  (Sclk),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Sclk = ~Sclk;

    int n_checks = 0;
    int n_errors = 0;
    int n_rj_wr  = 0;
    int n_cf_wr  = 0;
    int n_multi  = 0;

    localparam int MEM_NONE = 0, MEM_RJ = 1, MEM_COEFF = 2, MEM_DATA = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write strobe bookkeeping over the whole run
    always @(posedge Sclk) begin
        if (!Clear) begin
            if (bus.rj_we)    n_rj_wr++;
            if (bus.coeff_we) n_cf_wr++;
            if ((32'(bus.rj_we) + 32'(bus.coeff_we) + 32'(bus.data_we)) > 1) n_multi++;
        end
    end

    // One-cycle in_flag word; checks the write one cycle later and start_compute two cycles later
    task automatic send(input logic [15:0] l, input logic [15:0] r, input int mem, input int addr);
        @(negedge Sclk);
        bus.in_flag = 1'b1;
        bus.dataL   = l;
        bus.dataR   = r;
        @(posedge Sclk);
        #1;
        bus.in_flag = 1'b0;
        check("rj_we",    32'(bus.rj_we),    32'(mem == MEM_RJ));
        check("coeff_we", 32'(bus.coeff_we), 32'(mem == MEM_COEFF));
        check("data_we",  32'(bus.data_we),  32'(mem == MEM_DATA));
        if (mem == MEM_RJ)    check("rj_addr",    32'(bus.rj_addr),    32'(addr));
        if (mem == MEM_COEFF) check("coeff_addr", 32'(bus.coeff_addr), 32'(addr));
        if (mem == MEM_DATA) begin
            check("data_addr", 32'(bus.data_addr), 32'(addr));
            check("data_zero", 32'(bus.data_zero), 32'(0));
        end
        @(posedge Sclk);
        #1;
        check("start_compute", 32'(bus.start_compute), 32'(mem == MEM_DATA));
        if (mem == MEM_DATA) check("newest_ptr", 32'(bus.newest_ptr), 32'(addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ptr;
        Clear            = 1'b1;
        bus.in_flag      = 1'b0;
        bus.dataL        = '0;
        bus.dataR        = '0;
        bus.Flush        = 1'b0;
        bus.compute_busy = 1'b0;
        repeat (3) @(posedge Sclk);
        #1;
        check("rst_state",   32'(bus.state),       32'(0));
        check("rst_inready", 32'(bus.InReady),     32'(0));
        check("rst_sleep",   32'(bus.Sleep_flag),  32'(0));
        check("rst_err",     32'(bus.err_overrun), 32'(0));
        check("rst_data_we", 32'(bus.data_we),     32'(0));

        // INIT sweep: 256 zero writes, one per cycle
        @(negedge Sclk);
        Clear = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(posedge Sclk);
            #1;
            check("init_we",   32'(bus.data_we),   32'(1));
            check("init_zero", 32'(bus.data_zero), 32'(1));
            check("init_addr", 32'(bus.data_addr), 32'(i));
            check("init_ready", 32'(bus.InReady),  32'(i == 255));
        end
        @(posedge Sclk);
        #1;
        check("wait_rj_state", 32'(bus.state),   32'(1));
        check("wait_rj_ready", 32'(bus.InReady), 32'(1));
        check("post_init_we",  32'(bus.data_we), 32'(0));

        for (int i = 0; i < 16; i++) send(16'(i + 1), 16'h0, MEM_RJ, i);
        check("after_rj_state", 32'(bus.state), 32'(3));
        for (int i = 0; i < 512; i++) send(16'(i + 100), 16'h0, MEM_COEFF, i);
        check("after_coeff_state", 32'(bus.state), 32'(5));

        // 300 nonzero samples: address wraps 255 -> 0 at sample 257
        for (int s = 1; s <= 300; s++) send(16'(s), 16'(s) ^ 16'h5a5a, MEM_DATA, (s - 1) % 256);
        check("working_state", 32'(bus.state), 32'(6));

        // 800 zero samples: the 800th is still written, then SLEEP
        ptr = 300 % 256;
        for (int j = 0; j < 800; j++) begin
            check("pre_limit_sleep", 32'(bus.Sleep_flag), 32'(0));
            send(16'h0, 16'h0, MEM_DATA, (ptr + j) % 256);
        end
        check("sleep_flag", 32'(bus.Sleep_flag), 32'(1));
        check("sleep_state", 32'(bus.state), 32'(7));
        ptr = (ptr + 800) % 256;
        for (int j = 0; j < 5; j++) send(16'h0, 16'h0, MEM_NONE, 0);
        check("still_sleep", 32'(bus.state), 32'(7));
        send(16'h0001, 16'h0000, MEM_DATA, ptr);
        check("wake_sleep_flag", 32'(bus.Sleep_flag), 32'(0));
        check("wake_state", 32'(bus.state), 32'(6));

        // Flush together with a word: word dropped, sweep, hold, then WAIT_INPUT with ptr=0
        @(negedge Sclk);
        bus.in_flag = 1'b1;
        bus.dataL   = 16'h1234;
        bus.dataR   = 16'h5678;
        bus.Flush   = 1'b1;
        @(posedge Sclk);
        #1;
        bus.in_flag = 1'b0;
        check("flush_drop_we", 32'(bus.data_we), 32'(0));
        check("flush_state",   32'(bus.state),   32'(8));
        check("flush_ready",   32'(bus.InReady), 32'(0));
        for (int i = 0; i < 256; i++) begin
            @(posedge Sclk);
            #1;
            check("clr_we",   32'(bus.data_we),   32'(1));
            check("clr_zero", 32'(bus.data_zero), 32'(1));
            check("clr_addr", 32'(bus.data_addr), 32'(i));
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge Sclk);
            #1;
            check("clr_hold_state", 32'(bus.state),   32'(8));
            check("clr_hold_we",    32'(bus.data_we), 32'(0));
        end
        @(negedge Sclk);
        bus.Flush = 1'b0;
        for (int i = 0; i < 5 && bus.state != 4'd5; i++) begin
            @(posedge Sclk);
            #1;
        end
        check("post_flush_state", 32'(bus.state),   32'(5));
        check("post_flush_ready", 32'(bus.InReady), 32'(1));
        send(16'h00aa, 16'h00bb, MEM_DATA, 0);
        check("rj_writes_total",    32'(n_rj_wr), 32'(16));
        check("coeff_writes_total", 32'(n_cf_wr), 32'(512));
        check("one_hot_we",         32'(n_multi), 32'(0));

        // Overrun: start_compute while compute_busy is high is sticky until Clear
        check("err_before", 32'(bus.err_overrun), 32'(0));
        bus.compute_busy = 1'b1;
        send(16'h0003, 16'h0004, MEM_DATA, 1);
        @(posedge Sclk);
        #1;
        bus.compute_busy = 1'b0;
        check("err_set", 32'(bus.err_overrun), 32'(1));
        send(16'h0005, 16'h0006, MEM_DATA, 2);
        repeat (3) @(posedge Sclk);
        #1;
        check("err_sticky", 32'(bus.err_overrun), 32'(1));
        @(negedge Sclk);
        Clear = 1'b1;
        @(posedge Sclk);
        #1;
        check("err_cleared",   32'(bus.err_overrun), 32'(0));
        check("reclear_state", 32'(bus.state),       32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
